// File: rtl/hex_segment_reader.sv
// hex_segment_reader: reads a time-multiplexed active-low 7-seg bus back
// into hex digits and hands complete frames out over valid/ready.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   seg_n_i        active-low segments; bit 6 = seg 0 (top) ... bit 0 = seg 6
//                  (middle), so the bus read as a 7-bit number matches the
//                  decode table with seg 0 as MSB
//   dig_sel_i      one-hot strobe of the digit currently driven
//   frame_ready_i  consumer accepts the presented frame
//   frame_valid_o  frame_digits_o / frame_blank_o hold a complete frame
//   frame_digits_o digit k in bits [4k+3:4k]
//   frame_blank_o  digit k was blank (all segments off)
//   code_err_o     one-cycle pulse: a stable but unrecognised pattern
module hex_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [6:0]              seg_n_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    input  logic                    frame_ready_i,
    output logic                    frame_valid_o,
    output logic [4*NUM_DIGITS-1:0] frame_digits_o,
    output logic [NUM_DIGITS-1:0]   frame_blank_o,
    output logic                    code_err_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_e;

    logic [SYNC_STAGES-1:0][6:0]            seg_sync_q, seg_sync_d;
    logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] sel_sync_q, sel_sync_d;

    logic [6:0]                   seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]        sel_prev_q, sel_prev_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]   work_dig_q, work_dig_d;
    logic [NUM_DIGITS-1:0]        work_blank_q, work_blank_d;
    logic [NUM_DIGITS-1:0]        mask_q, mask_d;
    logic [NUM_DIGITS-1:0][3:0]   frame_dig_q, frame_dig_d;
    logic [NUM_DIGITS-1:0]        frame_blank_q, frame_blank_d;
    logic                         code_err_q, code_err_d;
    state_e                       state_q, state_d;

    logic [6:0]            seg_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic                  sel_ok;
    logic                  same;
    logic                  commit;
    logic                  load;
    logic                  dec_ok;
    logic                  dec_blank;
    logic [3:0]            dec_nib;
    logic [IW-1:0]         idx;

    assign seg_s = seg_sync_q[SYNC_STAGES-1];
    assign sel_s = sel_sync_q[SYNC_STAGES-1];

    assign seg_sync_d = {seg_sync_q[SYNC_STAGES-2:0], seg_n_i};
    assign sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], dig_sel_i};

    assign sel_ok = $onehot(sel_s);
    assign same   = (seg_s == seg_prev_q) && (sel_s == sel_prev_q);
    // Fires once per stable run: only on the step into saturation.
    assign commit = sel_ok && same && (cnt_q == CW'(STABLE_CYCLES - 1));

    assign seg_prev_d = seg_s;
    assign sel_prev_d = sel_s;

    always_comb begin
        cnt_d = '0;
        if (!sel_ok) begin
            cnt_d = '0;
        end else if (same) begin
            if (cnt_q == CW'(STABLE_CYCLES)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = CW'(1);
        end
    end

    always_comb begin
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        dec_nib   = 4'h0;
        unique case (seg_s)
            7'h01: dec_nib = 4'h0;
            7'h4F: dec_nib = 4'h1;
            7'h12: dec_nib = 4'h2;
            7'h06: dec_nib = 4'h3;
            7'h4C: dec_nib = 4'h4;
            7'h24: dec_nib = 4'h5;
            7'h20: dec_nib = 4'h6;
            7'h0F: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h04: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h60: dec_nib = 4'hB;
            7'h31: dec_nib = 4'hC;
            7'h42: dec_nib = 4'hD;
            7'h30: dec_nib = 4'hE;
            7'h38: dec_nib = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_s[k]) begin
                idx = IW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (&mask_q) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (frame_ready_i) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Frame outputs take the working regs before this cycle's commit, and
    // the mask is cleared before the commit bit lands, so a digit committed
    // on the hand-off cycle belongs to the next frame.
    always_comb begin
        work_dig_d    = work_dig_q;
        work_blank_d  = work_blank_q;
        mask_d        = mask_q;
        frame_dig_d   = frame_dig_q;
        frame_blank_d = frame_blank_q;
        code_err_d    = commit && !dec_ok;
        if (load) begin
            frame_dig_d   = work_dig_q;
            frame_blank_d = work_blank_q;
            mask_d        = '0;
        end
        if (commit && dec_ok) begin
            work_dig_d[idx]   = dec_nib;
            work_blank_d[idx] = dec_blank;
            mask_d[idx]       = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_sync_q    <= '0;
            sel_sync_q    <= '0;
            seg_prev_q    <= '0;
            sel_prev_q    <= '0;
            cnt_q         <= '0;
            work_dig_q    <= '0;
            work_blank_q  <= '0;
            mask_q        <= '0;
            frame_dig_q   <= '0;
            frame_blank_q <= '0;
            code_err_q    <= 1'b0;
            state_q       <= COLLECT;
        end else begin
            seg_sync_q    <= seg_sync_d;
            sel_sync_q    <= sel_sync_d;
            seg_prev_q    <= seg_prev_d;
            sel_prev_q    <= sel_prev_d;
            cnt_q         <= cnt_d;
            work_dig_q    <= work_dig_d;
            work_blank_q  <= work_blank_d;
            mask_q        <= mask_d;
            frame_dig_q   <= frame_dig_d;
            frame_blank_q <= frame_blank_d;
            code_err_q    <= code_err_d;
            state_q       <= state_d;
        end
    end

    assign frame_valid_o  = (state_q == PRESENT);
    assign frame_digits_o = frame_dig_q;
    assign frame_blank_o  = frame_blank_q;
    assign code_err_o     = code_err_q;

endmodule

// File: tb/tb_hex_segment_reader.sv
// tb_hex_segment_reader: directed scenarios plus random bus traffic,
// checked every cycle against a sample-history reference model.
module tb_hex_segment_reader;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int SY = 2;

    localparam logic [6:0] PAT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic [6:0]   seg   = 7'h7F;
    logic [N-1:0] sel   = '0;
    logic         ready = 1'b0;

    logic           fv;
    logic [4*N-1:0] fd;
    logic [N-1:0]   fb;
    logic           ce;

    int checks   = 0;
    int errors   = 0;
    int cerr_cnt = 0;

    always #5 clk = ~clk;

    hex_segment_reader #(
        .NUM_DIGITS   (N),
        .STABLE_CYCLES(S),
        .SYNC_STAGES  (SY)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .seg_n_i       (seg),
        .dig_sel_i     (sel),
        .frame_ready_i (ready),
        .frame_valid_o (fv),
        .frame_digits_o(fd),
        .frame_blank_o (fb),
        .code_err_o    (ce)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // raw holds every {seg,sel} applied since reset; the synchronised view
    // is simply that history delayed by SY samples, zeros before reset.
    logic [6+N:0]   raw [$];
    logic           m_fv   = 1'b0;
    logic [4*N-1:0] m_dig  = '0;
    logic [N-1:0]   m_blk  = '0;
    logic [N-1:0]   m_mask = '0;
    logic           m_cerr = 1'b0;
    logic [3:0]     w_dig [N];
    logic [N-1:0]   w_blk  = '0;

    function automatic int decode(input logic [6:0] s);
        if (s == 7'h7F) return 16;
        for (int i = 0; i < 16; i++) begin
            if (PAT[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic logic [6+N:0] sample(input int i);
        if (i < 0) return '0;
        return raw[i];
    endfunction

    task automatic model_reset();
        raw.delete();
        m_fv   = 1'b0;
        m_dig  = '0;
        m_blk  = '0;
        m_mask = '0;
        m_cerr = 1'b0;
        w_blk  = '0;
        for (int i = 0; i < N; i++) w_dig[i] = 4'h0;
    endtask

    task automatic model_step();
        logic [6+N:0] cur;
        int           base;
        int           run;
        int           code;
        int           k;
        logic         commit;
        raw.push_back({seg, sel});
        base   = raw.size() - 1 - SY;
        cur    = sample(base);
        commit = 1'b0;
        if ($onehot(cur[N-1:0])) begin
            run = 0;
            while (run <= S && sample(base - run) == cur) run++;
            commit = (run == S);
        end
        if (!m_fv) begin
            if (m_mask == '1) begin
                for (int i = 0; i < N; i++) m_dig[4*i +: 4] = w_dig[i];
                m_blk  = w_blk;
                m_mask = '0;
                m_fv   = 1'b1;
            end
        end else if (ready) begin
            m_fv = 1'b0;
        end
        m_cerr = 1'b0;
        if (commit) begin
            code = decode(cur[6+N:N]);
            k    = 0;
            for (int i = 0; i < N; i++) if (cur[i]) k = i;
            if (code < 0) begin
                m_cerr = 1'b1;
            end else begin
                w_dig[k]  = (code == 16) ? 4'h0 : 4'(code);
                w_blk[k]  = (code == 16);
                m_mask[k] = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("valid", fv, m_fv);
            chk("digits", fd, m_dig);
            chk("blank", fb, m_blk);
            chk("code_err", ce, m_cerr);
            if (ce) cerr_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [6:0] s, input logic [N-1:0] d,
                         input int n);
        seg = s;
        sel = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(7'h7F, '0, n);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", fv, 0);
        chk("rst_digits", fd, 0);
        chk("rst_blank", fb, 0);
        chk("rst_cerr", ce, 0);
        rst = 1'b0;
        idle(4);

        // frame A, held un-accepted
        drive(7'h06, 4'b0001, 16);
        drive(7'h4C, 4'b0010, 16);
        drive(7'h24, 4'b0100, 16);
        seg = 7'h20;
        sel = 4'b1000;
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (fv && lat < 0) lat = i;
        end
        chk("t1_latency", lat, SY + S + 1);
        chk("t1_digits", fd, 16'h6543);
        chk("t1_blank", fb, 4'b0000);

        // frame B collected behind the held frame A
        drive(7'h08, 4'b0001, 16);
        drive(7'h7F, 4'b0010, 16);
        drive(7'h60, 4'b0100, 16);
        drive(7'h31, 4'b1000, 16);
        idle(200);
        chk("t5_held_valid", fv, 1);
        chk("t5_held_digits", fd, 16'h6543);
        accept();
        chk("t5_bubble", fv, 0);
        @(negedge clk);
        chk("t5_next_valid", fv, 1);
        chk("t2_digits", fd, 16'hCB0A);
        chk("t2_blank", fb, 4'b0010);
        accept();
        idle(4);

        // unrecognised pattern on digit 2
        cerr_cnt = 0;
        drive(7'h01, 4'b0001, 16);
        drive(7'h4F, 4'b0010, 16);
        drive(7'h7E, 4'b0100, 16);
        drive(7'h06, 4'b1000, 16);
        idle(8);
        chk("t3_cerr_pulses", cerr_cnt, 1);
        chk("t3_no_frame", fv, 0);
        drive(7'h12, 4'b0100, 16);
        idle(2);
        chk("t3_valid", fv, 1);
        chk("t3_digits", fd, 16'h3210);
        accept();
        idle(4);

        // glitching segments and a two-hot strobe never commit
        cerr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 7'h12 : 7'h06, 4'b0001, 3);
        end
        drive(7'h12, 4'b0011, 20);
        drive(7'h4F, 4'b0010, 16);
        drive(7'h12, 4'b0100, 16);
        drive(7'h06, 4'b1000, 16);
        idle(8);
        chk("t4_no_frame", fv, 0);
        chk("t4_no_cerr", cerr_cnt, 0);
        drive(7'h04, 4'b0001, 16);
        idle(2);
        chk("t4_valid", fv, 1);
        chk("t4_digits", fd, 16'h3219);

        // async reset mid-collection with a frame still presented
        drive(7'h01, 4'b0001, 16);
        drive(7'h4F, 4'b0010, 16);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", fv, 0);
        chk("t6_async_digits", fd, 0);
        chk("t6_async_blank", fb, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(7'h12, 4'b0100, 16);
        drive(7'h06, 4'b1000, 16);
        idle(8);
        chk("t6_no_frame", fv, 0);
        drive(7'h01, 4'b0001, 16);
        drive(7'h4F, 4'b0010, 16);
        idle(2);
        chk("t6_valid", fv, 1);
        chk("t6_digits", fd, 16'h3210);
        accept();
        idle(4);

        // random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            int r2;
            int n;
            r  = $urandom_range(0, 9);
            r2 = $urandom_range(0, 19);
            n  = $urandom_range(1, 20);
            if (r < 7) sel = N'(1) << $urandom_range(0, N - 1);
            else if (r == 7) sel = '0;
            else sel = N'($urandom);
            if (r2 < 16) seg = PAT[r2];
            else if (r2 < 18) seg = 7'h7F;
            else seg = 7'($urandom);
            for (int c = 0; c < n; c++) begin
                ready = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        ready = 1'b0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
